// File: rtl/alu_issue_queue.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : alu_issue_queue                                             |
// | Description : RV32I ALU-op decoder feeding a DEPTH-entry issue FIFO.      |
// |               Define ALU_ISSUE_IMM_EN to also decode OP-IMM (0010011).    |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
module alu_issue_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instr,
    input  logic [31:0]              rs1_data,
    input  logic [31:0]              rs2_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2:0]               alu_opcode,
    output logic [31:0]              op_0,
    output logic [31:0]              op_1,
    output logic [4:0]               rd,
    output logic                     illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int         c_AW      = $clog2(DEPTH);
    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_SUB  = 3'b001;
    localparam logic [2:0] c_OP_AND  = 3'b010;
    localparam logic [2:0] c_OP_OR   = 3'b011;
    localparam logic [2:0] c_OP_XOR  = 3'b100;
    localparam logic [2:0] c_OP_SLL  = 3'b101;
    localparam logic [2:0] c_OP_SRL  = 3'b110;
    localparam logic [2:0] c_OP_SRA  = 3'b111;
    localparam logic [6:0] c_F7_BASE = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);
    localparam logic [c_AW:0]   c_CNT_ONE = (c_AW + 1)'(1);

    logic [2:0]      r_mem_opc [DEPTH];
    logic [31:0]     r_mem_op0 [DEPTH];
    logic [31:0]     r_mem_op1 [DEPTH];
    logic [4:0]      r_mem_rd  [DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_AW:0]   r_count;
    logic            r_illegal;

    logic        w_legal;
    logic [2:0]  w_opc;
    logic [31:0] w_op1;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic [6:0]  w_f7;
    logic [2:0]  w_f3;

    assign w_f7 = instr[31:25];
    assign w_f3 = instr[14:12];

    always_comb begin
        w_legal = 1'b0;
        w_opc   = c_OP_ADD;
        w_op1   = rs2_data;
        case (instr[6:0])
            7'b0110011: begin
                if (w_f7 == c_F7_BASE) begin
                    w_legal = 1'b1;
                    case (w_f3)
                        3'b000:  w_opc = c_OP_ADD;
                        3'b111:  w_opc = c_OP_AND;
                        3'b110:  w_opc = c_OP_OR;
                        3'b100:  w_opc = c_OP_XOR;
                        3'b001:  w_opc = c_OP_SLL;
                        3'b101:  w_opc = c_OP_SRL;
                        default: w_legal = 1'b0;
                    endcase
                end else if (w_f7 == c_F7_ALT) begin
                    if (w_f3 == 3'b000) begin
                        w_legal = 1'b1;
                        w_opc   = c_OP_SUB;
                    end else if (w_f3 == 3'b101) begin
                        w_legal = 1'b1;
                        w_opc   = c_OP_SRA;
                    end
                end
            end
`ifdef ALU_ISSUE_IMM_EN
            7'b0010011: begin
                w_op1 = {{20{instr[31]}}, instr[31:20]};
                case (w_f3)
                    3'b000: begin w_legal = 1'b1; w_opc = c_OP_ADD; end
                    3'b111: begin w_legal = 1'b1; w_opc = c_OP_AND; end
                    3'b110: begin w_legal = 1'b1; w_opc = c_OP_OR;  end
                    3'b100: begin w_legal = 1'b1; w_opc = c_OP_XOR; end
                    // Shifts carry shamt in imm[4:0]; imm[11:5] selects the variant.
                    3'b001: begin
                        w_op1   = {27'd0, instr[24:20]};
                        w_legal = (w_f7 == c_F7_BASE);
                        w_opc   = c_OP_SLL;
                    end
                    3'b101: begin
                        w_op1   = {27'd0, instr[24:20]};
                        w_legal = (w_f7 == c_F7_BASE) || (w_f7 == c_F7_ALT);
                        w_opc   = (w_f7 == c_F7_ALT) ? c_OP_SRA : c_OP_SRL;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
`endif
            default: w_legal = 1'b0;
        endcase
    end

    // Count MSB is set only at DEPTH, so it doubles as the full flag.
    assign in_ready  = ~r_count[c_AW];
    assign out_valid = |r_count;
    assign w_accept  = in_valid & in_ready;
    assign w_push    = w_accept & w_legal;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + c_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            r_illegal <= w_accept & ~w_legal;
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clock) begin
        if (w_push && !reset) begin
            r_mem_opc[r_wptr] <= w_opc;
            r_mem_op0[r_wptr] <= rs1_data;
            r_mem_op1[r_wptr] <= w_op1;
            r_mem_rd[r_wptr]  <= instr[11:7];
        end
    end

    assign alu_opcode = out_valid ? r_mem_opc[r_rptr] : 3'd0;
    assign op_0       = out_valid ? r_mem_op0[r_rptr] : 32'd0;
    assign op_1       = out_valid ? r_mem_op1[r_rptr] : 32'd0;
    assign rd         = out_valid ? r_mem_rd[r_rptr]  : 5'd0;
    assign illegal    = r_illegal;
    assign count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : tb_alu_issue_queue                                          |
// | Description : Scoreboard bench for alu_issue_queue (ALU_ISSUE_IMM_EN aware)|
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
module tb_alu_issue_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } entry_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  alu_opcode;
    logic [31:0] op_0;
    logic [31:0] op_1;
    logic [4:0]  rd;
    logic        illegal;
    logic [2:0]  count;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     m_count = 0;
    logic   m_illegal = 1'b0;
    entry_t sb[$];

    alu_issue_queue #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_opcode(alu_opcode), .op_0(op_0), .op_1(op_1), .rd(rd),
        .illegal(illegal), .count(count)
    );

    always #5 clock = ~clock;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference decode written straight from the ISA tables.
    function automatic bit ref_decode(input logic [31:0] ins, input logic [31:0] r2,
                                      output logic [2:0] op, output logic [31:0] b);
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = ins[31:25];
        f3 = ins[14:12];
        op = 3'd0;
        b  = r2;
        if (ins[6:0] == 7'h33) begin
            if (f7 == 7'h00) begin
                case (f3)
                    3'd0: op = 3'd0;
                    3'd7: op = 3'd2;
                    3'd6: op = 3'd3;
                    3'd4: op = 3'd4;
                    3'd1: op = 3'd5;
                    3'd5: op = 3'd6;
                    default: return 1'b0;
                endcase
                return 1'b1;
            end
            if (f7 == 7'h20 && f3 == 3'd0) begin op = 3'd1; return 1'b1; end
            if (f7 == 7'h20 && f3 == 3'd5) begin op = 3'd7; return 1'b1; end
            return 1'b0;
        end
`ifdef ALU_ISSUE_IMM_EN
        if (ins[6:0] == 7'h13) begin
            b = $signed(ins[31:20]);
            case (f3)
                3'd0: begin op = 3'd0; return 1'b1; end
                3'd7: begin op = 3'd2; return 1'b1; end
                3'd6: begin op = 3'd3; return 1'b1; end
                3'd4: begin op = 3'd4; return 1'b1; end
                default: ;
            endcase
            b = {27'd0, ins[24:20]};
            if (f3 == 3'd1 && f7 == 7'h00) begin op = 3'd5; return 1'b1; end
            if (f3 == 3'd5 && f7 == 7'h00) begin op = 3'd6; return 1'b1; end
            if (f3 == 3'd5 && f7 == 7'h20) begin op = 3'd7; return 1'b1; end
        end
`endif
        return 1'b0;
    endfunction

    // Model: on each edge enqueue expected entries for accepted legal pushes.
    always @(posedge clock) begin
        logic [2:0]  eop;
        logic [31:0] eb;
        bit          ok;
        bit          acc;
        bit          pop;
        if (reset) begin
            m_count   = 0;
            m_illegal = 1'b0;
            sb.delete();
        end else begin
            acc = in_valid && (m_count < DEPTH);
            pop = (m_count != 0) && out_ready;
            ok  = ref_decode(instr, rs2_data, eop, eb);
            if (acc && ok) begin
                sb.push_back('{op: eop, a: rs1_data, b: eb, rd: instr[11:7]});
                m_count++;
            end
            if (pop) m_count--;
            m_illegal = acc && !ok;
        end
    end

    // Monitor: compare status each cycle; head against scoreboard front, pop on consume.
    always @(negedge clock) begin
        entry_t e;
        chk("count", 32'(count), 32'(m_count));
        chk("in_ready", 32'(in_ready), 32'(m_count < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(m_count != 0));
        chk("illegal", 32'(illegal), 32'(m_illegal));
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'(out_valid), 32'd0);
            end else begin
                e = sb[0];
                chk("alu_opcode", 32'(alu_opcode), 32'(e.op));
                chk("op_0", op_0, e.a);
                chk("op_1", op_1, e.b);
                chk("rd", 32'(rd), 32'(e.rd));
                if (out_ready) void'(sb.pop_front());
            end
        end else begin
            chk("empty_fields", {alu_opcode, rd, 24'd0} | op_0 | op_1, 32'd0);
        end
    end

    task automatic cyc(input logic rst, input logic v, input logic [31:0] ins,
                       input logic [31:0] a, input logic [31:0] b, input logic ordy);
        reset = rst; in_valid = v; instr = ins;
        rs1_data = a; rs2_data = b; out_ready = ordy;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] opc;
        logic [6:0] f7;
        int k;
        int j;
        k = $urandom_range(0, 9);
        j = $urandom_range(0, 9);
        opc = (k < 6) ? 7'h33 : (k < 8) ? 7'h13 : 7'($urandom);
        f7  = (j < 5) ? 7'h00 : (j < 8) ? 7'h20 : 7'($urandom);
        return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
    endfunction

    initial begin
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        // add x3,x1,x2 held at the head, then drained
        cyc(0, 1, 32'h002081B3, 32'd5, 32'd7, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        // sra x5,x6,x7
        cyc(0, 1, 32'h407352B3, 32'h80000000, 32'd4, 0);
        cyc(0, 0, 0, 0, 0, 1);
        // slt is rejected
        cyc(0, 1, 32'h0020A1B3, 32'd1, 32'd2, 0);
        cyc(0, 0, 0, 0, 0, 0);
        // fill, attempt a push while full, then push+pop through pointer wrap
        for (int i = 0; i < DEPTH + 1; i++)
            cyc(0, 1, {7'h00, 5'd2, 5'd1, 3'd0, 5'(i + 1), 7'h33}, 32'(i), 32'(100 + i), 0);
        for (int i = 0; i < 6; i++)
            cyc(0, 1, {7'h20, 5'd2, 5'd1, 3'd0, 5'(i + 10), 7'h33}, 32'(200 + i), 32'(i), 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        // reset with two entries buffered and handshake activity
        cyc(0, 1, 32'h002081B3, 32'd1, 32'd1, 0);
        cyc(0, 1, 32'h002081B3, 32'd2, 32'd2, 0);
        cyc(1, 1, 32'h002081B3, 32'd3, 32'd3, 1);
        cyc(0, 0, 0, 0, 0, 0);
        // addi x1,x0,-1
        cyc(0, 1, 32'hFFF00093, 32'd0, 32'd9, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, rand_instr(),
                $urandom, $urandom, $urandom_range(0, 2) != 0);
        for (int i = 0; i < DEPTH + 2; i++)
            cyc(0, 0, 0, 0, 0, 1);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
